// File: rtl/hicore_commit_ctrl_pkg.sv
// Shared types for the HiCore commit controller: widths, FSM state encodings, commit-event classes.
// The optional build macro HICORE_VECTORED_MTVEC_EN is consumed in hicore_commit_ctrl.sv.
package hicore_commit_ctrl_pkg;

  localparam int HICORE_PC_SIZE      = 32;
  localparam int HICORE_EXCP_SIZE    = 16;
  localparam int HICORE_IRQ_SIZE     = 12;
  localparam int HICORE_CSR_IDX_SIZE = 12;

  typedef enum logic [1:0] {
    HICORE_CMT_BOOT  = 2'd0,
    HICORE_CMT_RUN   = 2'd1,
    HICORE_CMT_FLUSH = 2'd2,
    HICORE_CMT_WAIT  = 2'd3
  } cmt_state_e;

  typedef enum logic [2:0] {
    EV_NONE = 3'd0,
    EV_EXCP = 3'd1,
    EV_IRQ  = 3'd2,
    EV_MRET = 3'd3,
    EV_CSR  = 3'd4
  } cmt_event_e;

  // Redirect-causing event of a valid head, highest priority first.
  function automatic cmt_event_e cmt_classify(input logic excp_any, input logic irq_any,
                                              input logic mret, input logic csr_need);
    if (excp_any) return EV_EXCP;
    if (irq_any)  return EV_IRQ;
    if (mret)     return EV_MRET;
    if (csr_need) return EV_CSR;
    return EV_NONE;
  endfunction

endpackage

// File: rtl/hicore_commit_ctrl_if.sv
// Bus bundle between the commit controller (master) and its ROB / CSR unit / frontend neighbours (slave).
interface hicore_commit_ctrl_if
  import hicore_commit_ctrl_pkg::*;
#(
  parameter int PC_W   = HICORE_PC_SIZE,
  parameter int EXCP_W = HICORE_EXCP_SIZE,
  parameter int IRQ_W  = HICORE_IRQ_SIZE
) ();

  logic                           rob_head_valid;
  logic [EXCP_W-1:0]              rob_head_excp;
  logic [PC_W-1:0]                rob_head_pc;
  logic [PC_W-1:0]                rob_head_next_pc;
  logic                           rob_head_csr_need;
  logic [HICORE_CSR_IDX_SIZE-1:0] rob_head_csr_idx;
  logic [PC_W-1:0]                rob_head_csr_data;
  logic                           rob_head_mret;
  logic                           rob_retire;

  logic [IRQ_W-1:0]               irq_pend;
  logic [IRQ_W-1:0]               irq_msk;
  logic [PC_W-1:0]                csr_mepc;
  logic [PC_W-1:0]                csr_mtvec;

  logic                           commit_valid;
  logic [EXCP_W-1:0]              commit_excp;
  logic [IRQ_W-1:0]               commit_irq;
  logic [PC_W-1:0]                commit_pc;
  logic [PC_W-1:0]                commit_next_pc;
  logic                           commit_csr_need;
  logic [HICORE_CSR_IDX_SIZE-1:0] commit_csr_idx;
  logic [PC_W-1:0]                commit_csr_data;
  logic                           commit_mret_op;

  logic                           flush;
  logic                           redirect_valid;
  logic [PC_W-1:0]                redirect_pc;
  logic                           redirect_ready;

  modport master (
    input  rob_head_valid, rob_head_excp, rob_head_pc, rob_head_next_pc,
           rob_head_csr_need, rob_head_csr_idx, rob_head_csr_data, rob_head_mret,
           irq_pend, irq_msk, csr_mepc, csr_mtvec, redirect_ready,
    output rob_retire, commit_valid, commit_excp, commit_irq, commit_pc, commit_next_pc,
           commit_csr_need, commit_csr_idx, commit_csr_data, commit_mret_op,
           flush, redirect_valid, redirect_pc
  );

  modport slave (
    output rob_head_valid, rob_head_excp, rob_head_pc, rob_head_next_pc,
           rob_head_csr_need, rob_head_csr_idx, rob_head_csr_data, rob_head_mret,
           irq_pend, irq_msk, csr_mepc, csr_mtvec, redirect_ready,
    input  rob_retire, commit_valid, commit_excp, commit_irq, commit_pc, commit_next_pc,
           commit_csr_need, commit_csr_idx, commit_csr_data, commit_mret_op,
           flush, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/hicore_irq_prio_enc.sv
// Lowest-set-bit encoder for the enabled interrupt vector; the index equals the mcause interrupt code.
module hicore_irq_prio_enc #(
  parameter int IRQ_W = 12
) (
  input  logic [IRQ_W-1:0] irq_vec,
  output logic [3:0]       irq_idx
);

  logic [IRQ_W-1:0] first;

  // first[gi] is set only for the lowest set bit of irq_vec
  for (genvar gi = 0; gi < IRQ_W; gi++) begin : g_first
    localparam logic [IRQ_W-1:0] LOW_MASK = IRQ_W'((1 << gi) - 1);
    assign first[gi] = irq_vec[gi] & ~|(irq_vec & LOW_MASK);
  end

  always_comb begin
    irq_idx = '0;
    for (int i = 0; i < IRQ_W; i++) begin
      if (first[i]) irq_idx = irq_idx | 4'(i);
    end
  end

endmodule

// File: rtl/hicore_commit_ctrl.sv
// Retirement / trap controller at the ROB head: retires, raises traps, owns flush and frontend redirect.
// Build option HICORE_VECTORED_MTVEC_EN: interrupts vector to base + 4*cause when mtvec[1:0]==2'b01.
module hicore_commit_ctrl
  import hicore_commit_ctrl_pkg::*;
#(
  parameter int              PC_W      = HICORE_PC_SIZE,
  parameter int              EXCP_W    = HICORE_EXCP_SIZE,
  parameter int              IRQ_W     = HICORE_IRQ_SIZE,
  parameter int              FLUSH_CYC = 2,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(32'h8000_0000)
) (
  input logic                  clk,
  input logic                  rst_n,
  hicore_commit_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(FLUSH_CYC + 1);

  cmt_state_e       state_q, state_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             flush_q, flush_d;
  logic             rdr_valid_q, rdr_valid_d;
  logic [PC_W-1:0]  rdr_pc_q, rdr_pc_d;

  logic             head_go;
  logic             excp_any;
  logic [IRQ_W-1:0] irqv;
  cmt_event_e       ev;
  logic [PC_W-1:0]  mtvec_base;
  logic [PC_W-1:0]  trap_pc;
  logic [PC_W-1:0]  target_pc;

  assign head_go    = (state_q == HICORE_CMT_RUN) && bus.rob_head_valid;
  assign excp_any   = |bus.rob_head_excp;
  assign irqv       = bus.irq_pend & bus.irq_msk;
  assign ev         = cmt_classify(excp_any, |irqv, bus.rob_head_mret, bus.rob_head_csr_need);
  assign mtvec_base = {bus.csr_mtvec[PC_W-1:2], 2'b00};

`ifdef HICORE_VECTORED_MTVEC_EN
  logic [3:0] irq_idx;

  hicore_irq_prio_enc #(.IRQ_W(IRQ_W)) u_irq_enc (
    .irq_vec (irqv),
    .irq_idx (irq_idx)
  );

  // Exceptions always land on the base; only interrupts honour vectored mode.
  always_comb begin
    trap_pc = mtvec_base;
    if (ev == EV_IRQ && bus.csr_mtvec[1:0] == 2'b01) begin
      trap_pc = mtvec_base + {{(PC_W-6){1'b0}}, irq_idx, 2'b00};
    end
  end
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^bus.csr_mtvec[1:0];
  assign trap_pc = mtvec_base;
`endif

  always_comb begin
    case (ev)
      EV_EXCP, EV_IRQ: target_pc = trap_pc;
      EV_MRET:         target_pc = bus.csr_mepc;
      default:         target_pc = bus.rob_head_next_pc;
    endcase
  end

  // Commit bus is combinational from the head and forced to zero whenever nothing commits.
  assign bus.rob_retire      = head_go;
  assign bus.commit_valid    = head_go;
  assign bus.commit_excp     = head_go ? bus.rob_head_excp : '0;
  assign bus.commit_irq      = (head_go && !excp_any) ? irqv : '0;
  assign bus.commit_pc       = head_go ? bus.rob_head_pc : '0;
  assign bus.commit_next_pc  = head_go ? bus.rob_head_next_pc : '0;
  assign bus.commit_csr_need = head_go && bus.rob_head_csr_need;
  assign bus.commit_csr_idx  = head_go ? bus.rob_head_csr_idx : '0;
  assign bus.commit_csr_data = head_go ? bus.rob_head_csr_data : '0;
  assign bus.commit_mret_op  = head_go && bus.rob_head_mret;

  assign bus.flush          = flush_q;
  assign bus.redirect_valid = rdr_valid_q;
  assign bus.redirect_pc    = rdr_pc_q;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    flush_d     = flush_q;
    rdr_valid_d = rdr_valid_q;
    rdr_pc_d    = rdr_pc_q;
    case (state_q)
      HICORE_CMT_BOOT: begin
        state_d     = HICORE_CMT_WAIT;
        rdr_valid_d = 1'b1;
        rdr_pc_d    = RESET_PC;
      end
      HICORE_CMT_RUN: begin
        if (head_go && ev != EV_NONE) begin
          state_d     = HICORE_CMT_FLUSH;
          flush_d     = 1'b1;
          flush_cnt_d = CNT_W'(FLUSH_CYC - 1);
          rdr_valid_d = 1'b1;
          rdr_pc_d    = target_pc;
        end
      end
      HICORE_CMT_FLUSH: begin
        // redirect is already offered here, but acceptance only counts once flushing ends
        if (flush_cnt_q == '0) begin
          state_d = HICORE_CMT_WAIT;
          flush_d = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt_q - CNT_W'(1);
        end
      end
      HICORE_CMT_WAIT: begin
        if (bus.redirect_ready) begin
          state_d     = HICORE_CMT_RUN;
          rdr_valid_d = 1'b0;
        end
      end
      default: state_d = HICORE_CMT_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HICORE_CMT_BOOT;
      flush_cnt_q <= '0;
      flush_q     <= 1'b0;
      rdr_valid_q <= 1'b0;
      rdr_pc_q    <= RESET_PC;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      flush_q     <= flush_d;
      rdr_valid_q <= rdr_valid_d;
      rdr_pc_q    <= rdr_pc_d;
    end
  end

endmodule
